// File: rtl/video_pkg.sv
// Shared definitions for the scanline prefetch scheduler.
//   DEF_* constants : default geometry and memory-port characteristics
//   pixel_t         : one framebuffer word {r,g,b}
//   fetch_state_e   : scheduler FSM states
// The optional host fairness slot is enabled by defining VFS_HOST_SLOT_EN.
package video_pkg;

    localparam int DEF_H_ACTIVE    = 240;
    localparam int DEF_V_ACTIVE    = 320;
    localparam int DEF_ADDR_W      = 17;
    localparam int DEF_READ_LAT    = 2;
    localparam int DEF_MAX_OUTST   = 4;
    localparam int DEF_FAIR_PERIOD = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    localparam int DEF_DATA_W = $bits(pixel_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/video_fetch_sched_if.sv
// Single-port video memory bus shared by line fetch and host writes.
//   req/we/addr/wdata : request from the scheduler (held until gnt)
//   gnt               : memory accepts the request this cycle
//   rvalid/rdata      : read return, fixed latency after acceptance
// master = scheduler side, slave = memory side.
interface video_fetch_sched_if #(
    parameter int ADDR_W = video_pkg::DEF_ADDR_W,
    parameter int DATA_W = video_pkg::DEF_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/vfs_arbiter.sv
// Two-way memory-port arbiter: line fetch has fixed priority over host writes.
//   fetch_req/host_req   : requesters wanting the port this cycle
//   sel_fetch/sel_host   : one-hot (or none) owner of the port, combinational
// With VFS_HOST_SLOT_EN defined, clk/rst/idle/gnt ports are added and a counter
// of consecutive fetch grants taken while the host waits forces one host slot
// after DEF_FAIR_PERIOD of them. Without it the mux is purely combinational.
module vfs_arbiter
    import video_pkg::*;
(
`ifdef VFS_HOST_SLOT_EN
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic gnt,
`endif
    input  logic fetch_req,
    input  logic host_req,
    output logic sel_fetch,
    output logic sel_host
);

`ifdef VFS_HOST_SLOT_EN
    localparam int CW = $clog2(DEF_FAIR_PERIOD + 1);

    logic [CW-1:0] fetch_run;
    logic          force_host;

    assign force_host = (fetch_run == CW'(DEF_FAIR_PERIOD));
    assign sel_host   = host_req && (!fetch_req || force_host);
    assign sel_fetch  = fetch_req && !sel_host;

    // Saturation is implicit: once force_host is set a waiting host always wins.
    always_ff @(posedge clk) begin
        if (rst || idle) begin
            fetch_run <= '0;
        end else if (sel_host && gnt) begin
            fetch_run <= '0;
        end else if (sel_fetch && gnt && host_req) begin
            fetch_run <= fetch_run + 1'b1;
        end
    end
`else
    assign sel_fetch = fetch_req;
    assign sel_host  = host_req && !fetch_req;
`endif

endmodule

// File: rtl/video_fetch_sched.sv
// Scanline prefetch scheduler: copies one framebuffer line from shared video
// memory into a ping-pong line buffer, sharing the port with host pixel writes.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   frame_start              : clears the sticky underrun flag
//   line_req, line_idx       : request to fetch line line_idx
//   busy, underrun           : fetch in progress / request arrived while busy
//   wr_valid/ready/addr/data : host write stream
//   mem                      : shared memory bus (master side)
//   lb_we/addr/wdata         : line-buffer write, lb_addr = {bank, x}
// Optional feature: VFS_HOST_SLOT_EN adds a forced host slot (see vfs_arbiter).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a line request (new or queued)
// LOAD     | compute line base address and latch buffer bank
// FETCH    | issue H_ACTIVE reads, at most MAX_OUTST in flight
// DRAIN    | all reads issued, waiting for the remaining returns
module video_fetch_sched
    import video_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_OUTST = DEF_MAX_OUTST
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      line_req,
    input  logic [8:0]                line_idx,
    output logic                      busy,
    output logic                      underrun,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    video_fetch_sched_if.master       mem,
    output logic                      lb_we,
    output logic [$clog2(H_ACTIVE):0] lb_addr,
    output logic [DATA_W-1:0]         lb_wdata
);

    localparam int XW  = $clog2(H_ACTIVE + 1);
    localparam int LBX = $clog2(H_ACTIVE);
    localparam int OW  = $clog2(MAX_OUTST + 1);

    fetch_state_e      state;
    logic [8:0]        cur_idx;
    logic [8:0]        pend_idx;
    logic              pend_valid;
    logic [ADDR_W-1:0] base;
    logic              bank;
    logic [XW-1:0]     x_issue;
    logic [XW-1:0]     x_ret;
    logic [OW-1:0]     outstanding;

    logic idx_ok;
    logic fetch_want;
    logic host_want;
    logic sel_fetch;
    logic sel_host;
    logic fetch_acc;
    logic ret_ok;

    assign busy   = (state != ST_IDLE);
    assign idx_ok = line_req && ({23'd0, line_idx} < 32'(V_ACTIVE));

    // rst gates the requesters so every output reads 0 while reset is held.
    assign fetch_want = !rst && (state == ST_FETCH)
                        && (x_issue < XW'(H_ACTIVE))
                        && (outstanding < OW'(MAX_OUTST));
    assign host_want  = !rst && wr_valid;

    vfs_arbiter u_arb (
`ifdef VFS_HOST_SLOT_EN
        .clk       (clk),
        .rst       (rst),
        .idle      (state == ST_IDLE),
        .gnt       (mem.gnt),
`endif
        .fetch_req (fetch_want),
        .host_req  (host_want),
        .sel_fetch (sel_fetch),
        .sel_host  (sel_host)
    );

    assign mem.req   = sel_fetch || sel_host;
    assign mem.we    = sel_host;
    assign wr_ready  = sel_host && mem.gnt;
    assign fetch_acc = sel_fetch && mem.gnt;

    always_comb begin
        mem.addr  = '0;
        mem.wdata = '0;
        if (sel_fetch) begin
            mem.addr = base + ADDR_W'(x_issue);
        end else if (sel_host) begin
            mem.addr  = wr_addr;
            mem.wdata = wr_data;
        end
    end

    // Returns with nothing outstanding (e.g. after a mid-fetch reset) are stale.
    assign ret_ok   = !rst && mem.rvalid && (outstanding != '0);
    assign lb_we    = ret_ok;
    assign lb_addr  = ret_ok ? {bank, x_ret[LBX-1:0]} : '0;
    assign lb_wdata = ret_ok ? mem.rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cur_idx     <= '0;
            pend_idx    <= '0;
            pend_valid  <= 1'b0;
            base        <= '0;
            bank        <= 1'b0;
            x_issue     <= '0;
            x_ret       <= '0;
            outstanding <= '0;
            underrun    <= 1'b0;
        end else begin
            case ({fetch_acc, ret_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase

            if (fetch_acc) x_issue <= x_issue + 1'b1;
            if (ret_ok)    x_ret   <= x_ret + 1'b1;

            // A late request wins over a same-cycle frame_start clear.
            if (idx_ok && busy) begin
                underrun   <= 1'b1;
                pend_valid <= 1'b1;
                pend_idx   <= line_idx;
            end else if (frame_start) begin
                underrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (idx_ok) begin
                        cur_idx    <= line_idx;
                        pend_valid <= 1'b0;
                        state      <= ST_LOAD;
                    end else if (pend_valid) begin
                        cur_idx    <= pend_idx;
                        pend_valid <= 1'b0;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    base    <= ADDR_W'(32'(cur_idx) * 32'(H_ACTIVE));
                    bank    <= cur_idx[0];
                    x_issue <= '0;
                    x_ret   <= '0;
                    state   <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (fetch_acc && (x_issue == XW'(H_ACTIVE - 1))) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (x_ret == XW'(H_ACTIVE)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_fetch_sched.sv
module tb_video_fetch_sched;
    import video_pkg::*;

    localparam int H_ACTIVE = DEF_H_ACTIVE;
    localparam int ADDR_W   = DEF_ADDR_W;
    localparam int DATA_W   = DEF_DATA_W;
    localparam int LB_W     = $clog2(H_ACTIVE) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic              line_req;
    logic [8:0]        line_idx;
    logic              busy;
    logic              underrun;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              lb_we;
    logic [LB_W-1:0]   lb_addr;
    logic [DATA_W-1:0] lb_wdata;

    video_fetch_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    video_fetch_sched dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .line_req    (line_req),
        .line_idx    (line_idx),
        .busy        (busy),
        .underrun    (underrun),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem         (mem_bus),
        .lb_we       (lb_we),
        .lb_addr     (lb_addr),
        .lb_wdata    (lb_wdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } ret_t;

    ret_t                     rq[$];
    logic [ADDR_W-1:0]        exp_addr[$];
    logic [LB_W+DATA_W-1:0]   exp_lb[$];
    logic [ADDR_W+DATA_W-1:0] exp_wr[$];

    int cyc      = 0;
    int rd_cnt   = 0;
    int lb_cnt   = 0;
    int inflight = 0;
    int run      = 0;
    bit gnt_rand = 0;
    bit hold_pend = 0;
    logic [ADDR_W-1:0] hold_addr;

    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        return DATA_W'(32'(a) * 32'd13 + 32'd5);
    endfunction

    function automatic void push_line(input int idx);
        for (int x = 0; x < H_ACTIVE; x++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'(idx * H_ACTIVE + x);
            exp_addr.push_back(a);
            exp_lb.push_back({1'(idx & 1), (LB_W-1)'(x), data_of(a)});
        end
    endfunction

    // Memory model: grant (always or random), fixed-latency read return.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        mem_bus.gnt = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_bus.rvalid = 1'b1;
            mem_bus.rdata  = rq[0].data;
            void'(rq.pop_front());
        end else begin
            mem_bus.rvalid = 1'b0;
            mem_bus.rdata  = '0;
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic [ADDR_W-1:0]        ea;
        logic [LB_W+DATA_W-1:0]   el;
        logic [ADDR_W+DATA_W-1:0] ew;
        if (mem_bus.rvalid && inflight > 0) inflight--;
        if (mem_bus.req && !mem_bus.we && mem_bus.gnt) begin
            rd_cnt++;
            chk("rd_expected", exp_addr.size() != 0, 1);
            if (exp_addr.size() != 0) begin
                ea = exp_addr.pop_front();
                chk("rd_addr", mem_bus.addr, ea);
            end
            rq.push_back('{cyc + DEF_READ_LAT, data_of(mem_bus.addr)});
            inflight++;
            chk("inflight_max", inflight <= DEF_MAX_OUTST, 1);
            if (wr_valid) run++;
        end
        if (hold_pend && !rst && !wr_valid) begin
            chk("req_hold", mem_bus.req && !mem_bus.we, 1);
            chk("addr_hold", mem_bus.addr, hold_addr);
        end
        hold_pend = mem_bus.req && !mem_bus.we && !mem_bus.gnt;
        hold_addr = mem_bus.addr;
        if (lb_we) begin
            lb_cnt++;
            chk("lb_expected", exp_lb.size() != 0, 1);
            if (exp_lb.size() != 0) begin
                el = exp_lb.pop_front();
                chk("lb_addr", lb_addr, el[DATA_W +: LB_W]);
                chk("lb_wdata", lb_wdata, el[DATA_W-1:0]);
            end
        end
        if (wr_valid && wr_ready) begin
            chk("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
                ew = exp_wr.pop_front();
                chk("wr_addr", mem_bus.addr, ew[DATA_W +: ADDR_W]);
                chk("wr_wdata", mem_bus.wdata, ew[DATA_W-1:0]);
            end
            chk("wr_we", mem_bus.we, 1);
            if (exp_addr.size() != 0) begin
`ifdef VFS_HOST_SLOT_EN
                chk("host_slot_run", run, DEF_FAIR_PERIOD);
`else
                chk("host_during_fetch", exp_addr.size(), 0);
`endif
            end
            run = 0;
        end
        if (!busy) run = 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_line(input int idx, input bit fs);
        line_req    = 1'b1;
        line_idx    = 9'(idx);
        frame_start = fs;
        if (idx < DEF_V_ACTIVE) push_line(idx);
        tick();
        line_req    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while ((busy || exp_lb.size() != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk("done_in_time", busy || exp_lb.size() != 0, 0);
    endtask

    task automatic host_writes(input int n, input logic [ADDR_W-1:0] a0);
        for (int i = 0; i < n; i++) begin
            int  k;
            bit  got;
            wr_valid = 1'b1;
            wr_addr  = a0 + ADDR_W'(i);
            wr_data  = DATA_W'(32'hA50000 + i);
            exp_wr.push_back({wr_addr, wr_data});
            k = 0;
            do begin
                @(negedge clk);
                got = wr_ready;
                @(posedge clk);
                #1;
                k++;
            end while (!got && k < 2000);
            chk("wr_accepted", got, 1);
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int l0;
        int k;
        rst = 1'b1;
        frame_start = 1'b0;
        line_req = 1'b0;
        line_idx = '0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        mem_bus.gnt = 1'b0;
        mem_bus.rvalid = 1'b0;
        mem_bus.rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_mem_req", mem_bus.req, 0);
        chk("rst_lb_we", lb_we, 0);
        chk("rst_wr_ready", wr_ready, 0);

        // Line 0, grant always.
        r0 = rd_cnt;
        l0 = lb_cnt;
        req_line(0, 0);
        wait_done(2000);
        chk("l0_reads", rd_cnt - r0, H_ACTIVE);
        chk("l0_lb_writes", lb_cnt - l0, H_ACTIVE);
        chk("l0_busy_drop", busy, 0);

        // Line 5 (base 1200, bank 1) with random grant stalls.
        gnt_rand = 1;
        r0 = rd_cnt;
        req_line(5, 0);
        wait_done(6000);
        chk("l5_reads", rd_cnt - r0, H_ACTIVE);
        gnt_rand = 0;
        tick();

        // Host writes held during a fetch.
        r0 = rd_cnt;
        req_line(2, 0);
        k = 0;
        while (rd_cnt == r0 && k < 20) begin
            tick();
            k++;
        end
        chk("l2_fetch_started", rd_cnt != r0, 1);
        host_writes(40, ADDR_W'(32'h1000));
        wait_done(2000);
        chk("wr_all_done", exp_wr.size(), 0);

        // Underrun: line 7 requested during line 3.
        req_line(3, 0);
        repeat (20) tick();
        chk("underrun_pre", underrun, 0);
        req_line(7, 0);
        chk("underrun_set", underrun, 1);
        wait_done(4000);
        chk("underrun_sticky", underrun, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("underrun_clear", underrun, 0);

        // frame_start and line_req together while busy: set wins.
        req_line(4, 0);
        repeat (5) tick();
        req_line(9, 1);
        chk("underrun_set_wins", underrun, 1);
        wait_done(4000);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("underrun_clear2", underrun, 0);

        // Out-of-range line index ignored, idle and busy.
        req_line(320, 0);
        repeat (3) tick();
        chk("oor_idle_busy", busy, 0);
        chk("oor_idle_underrun", underrun, 0);
        req_line(1, 0);
        repeat (10) tick();
        req_line(330, 0);
        chk("oor_busy_underrun", underrun, 0);
        wait_done(2000);
        repeat (3) tick();
        chk("oor_no_refetch", busy, 0);

        // Reset mid-fetch after 100 reads.
        r0 = rd_cnt;
        req_line(6, 0);
        k = 0;
        while (rd_cnt - r0 < 100 && k < 1000) begin
            tick();
            k++;
        end
        chk("rst_mid_reach100", rd_cnt - r0 >= 100, 1);
        rst = 1'b1;
        exp_addr.delete();
        exp_lb.delete();
        @(negedge clk);
        chk("rst_mid_req", mem_bus.req, 0);
        chk("rst_mid_lb_we", lb_we, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        repeat (5) tick();
        chk("rst_mid_stay_idle", busy, 0);

        // Recovery: last line after reset.
        r0 = rd_cnt;
        req_line(319, 0);
        wait_done(2000);
        chk("l319_reads", rd_cnt - r0, H_ACTIVE);

        repeat (5) tick();
        chk("queues_empty", exp_addr.size() + exp_lb.size() + exp_wr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
